// File: rtl/fsqrt_seq.sv
// Multi-cycle IEEE-754 binary32 square root: special-case classification, subnormal
// normalization, restoring radix-2 recurrence and round-to-nearest-even.
`timescale 1ns/1ps
module fsqrt_seq #(
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] op_a,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags,
    output logic        busy
);
    localparam int N = 25 / ITER_PER_CYCLE;

    typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_op;
    logic [7:0]  r_exp;
    logic [49:0] r_x;
    logic [24:0] r_q;
    logic [26:0] r_rem;
    logic [4:0]  r_cnt;
    logic        r_spec_hold;
    logic [31:0] r_result;
    logic [4:0]  r_fflags;

    logic [7:0]  w_expf;
    logic [22:0] w_frac;
    logic        w_is_nan, w_is_inf, w_is_zero, w_special;
    logic [31:0] w_spec_res;
    logic [4:0]  w_spec_flags;
    logic [4:0]  w_lz;
    logic [23:0] w_m;
    logic [8:0]  w_eb9;
    logic [49:0] w_x;
    logic [24:0] w_q;
    logic [26:0] w_rem, w_rem_sh;
    logic [27:0] w_t;
    logic [24:0] w_sig25;
    logic [7:0]  w_rnd_exp;
    logic [31:0] w_rnd_res;

    assign w_expf    = r_op[30:23];
    assign w_frac    = r_op[22:0];
    assign w_is_nan  = (w_expf == 8'hFF) && (w_frac != 23'd0);
    assign w_is_inf  = (w_expf == 8'hFF) && (w_frac == 23'd0);
    assign w_is_zero = (w_expf == 8'h00) && (w_frac == 23'd0);
    assign w_special = w_is_nan || w_is_inf || w_is_zero || r_op[31];

    always_comb begin
        w_spec_res   = 32'h7F800000;
        w_spec_flags = 5'd0;
        if (w_is_nan) begin
            w_spec_res   = 32'h7FC00000;
            w_spec_flags = {~w_frac[22], 4'b0000};
        end else if (w_is_zero) begin
            w_spec_res = {r_op[31], 31'd0};
        end else if (r_op[31]) begin
            w_spec_res   = 32'h7FC00000;
            w_spec_flags = 5'b10000;
        end
    end

    // w_eb9 = 2*(biased result exponent) + (unbiased exponent is odd)
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (w_frac[i]) w_lz = 5'(22 - i);
        end
        if (w_expf == 8'h00) begin
            w_m   = {1'b0, w_frac} << (w_lz + 5'd1);
            w_eb9 = 9'd127 - {4'd0, w_lz};
        end else begin
            w_m   = {1'b1, w_frac};
            w_eb9 = {1'b0, w_expf} + 9'd127;
        end
    end

    always_comb begin
        w_rem    = r_rem;
        w_q      = r_q;
        w_x      = r_x;
        w_rem_sh = 27'd0;
        w_t      = 28'd0;
        for (int k = 0; k < ITER_PER_CYCLE; k++) begin
            w_rem_sh = {w_rem[24:0], w_x[49:48]};
            w_x      = {w_x[47:0], 2'b00};
            w_t      = {1'b0, w_rem_sh} - {1'b0, w_q, 2'b01};
            if (!w_t[27]) begin
                w_rem = w_t[26:0];
                w_q   = {w_q[23:0], 1'b1};
            end else begin
                w_rem = w_rem_sh;
                w_q   = {w_q[23:0], 1'b0};
            end
        end
    end

    assign w_sig25   = {1'b0, r_q[24:1]} + {24'd0, r_q[0]};
    assign w_rnd_exp = r_exp + {7'd0, w_sig25[24]};
    assign w_rnd_res = {1'b0, w_rnd_exp, (w_sig25[24] ? 23'd0 : w_sig25[22:0])};

    // Specials resolve after a second PREP cycle, giving them a fixed two-edge latency.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_state_nxt = PREP;
            PREP:    if (!w_special) w_state_nxt = ITER;
                     else if (r_spec_hold) w_state_nxt = DONE;
            ITER:    if (r_cnt == 5'(N - 1)) w_state_nxt = ROUND;
            ROUND:   w_state_nxt = DONE;
            DONE:    if (res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= 32'd0;
            r_exp       <= 8'd0;
            r_x         <= 50'd0;
            r_q         <= 25'd0;
            r_rem       <= 27'd0;
            r_cnt       <= 5'd0;
            r_spec_hold <= 1'b0;
            r_result    <= 32'd0;
            r_fflags    <= 5'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_spec_hold <= (r_state == PREP) && (w_state_nxt == PREP);
            if (r_state == IDLE && start_valid) r_op <= op_a;
            if (r_state == PREP && w_state_nxt == ITER) begin
                r_exp <= w_eb9[8:1];
                r_x   <= w_eb9[0] ? {w_m, 26'd0} : {1'b0, w_m, 25'd0};
                r_q   <= 25'd0;
                r_rem <= 27'd0;
                r_cnt <= 5'd0;
            end
            if (r_state == ITER) begin
                r_x   <= w_x;
                r_q   <= w_q;
                r_rem <= w_rem;
                r_cnt <= r_cnt + 5'd1;
            end
            if (r_state == PREP && w_state_nxt == DONE) begin
                r_result <= w_spec_res;
                r_fflags <= w_spec_flags;
            end
            if (r_state == ROUND && w_state_nxt == DONE) begin
                r_result <= w_rnd_res;
                r_fflags <= {4'b0000, r_q[0] | (r_rem != 27'd0)};
            end
        end
    end

    assign start_ready = (r_state == IDLE);
    assign res_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign result      = r_result;
    assign fflags      = r_fflags;
endmodule

// File: tb/tb_fsqrt_seq.sv
// Bench for fsqrt_seq: directed and random operands against an integer-sqrt reference,
// plus handshake, backpressure, flush and asynchronous reset scenarios for K=1 and K=5.
`timescale 1ns/1ps
module tb_fsqrt_seq;
    logic        clk = 1'b0;
    logic        rst_n, flush, sv, rr, sel;
    logic [31:0] op_a;
    logic        sr1, sr5, rv1, rv5, bz1, bz5;
    logic [31:0] res1, res5;
    logic [4:0]  ff1, ff5;
    logic        sv1, sv5, rr1, rr5;
    logic        w_sr, w_rv, w_bz;
    logic [31:0] w_res;
    logic [4:0]  w_ff;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign sv1   = sv & ~sel;
    assign sv5   = sv & sel;
    assign rr1   = sel ? 1'b1 : rr;
    assign rr5   = sel ? rr : 1'b1;
    assign w_sr  = sel ? sr5 : sr1;
    assign w_rv  = sel ? rv5 : rv1;
    assign w_bz  = sel ? bz5 : bz1;
    assign w_res = sel ? res5 : res1;
    assign w_ff  = sel ? ff5 : ff1;

    fsqrt_seq #(.ITER_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start_valid(sv1), .start_ready(sr1),
        .op_a(op_a), .res_valid(rv1), .res_ready(rr1), .result(res1), .fflags(ff1), .busy(bz1));
    fsqrt_seq #(.ITER_PER_CYCLE(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start_valid(sv5), .start_ready(sr5),
        .op_a(op_a), .res_valid(rv5), .res_ready(rr5), .result(res5), .fflags(ff5), .busy(bz5));

    function automatic longint isqrt(input longint x);
        longint r, t;
        r = 0;
        for (int b = 25; b >= 0; b--) begin
            t = r + (longint'(1) << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    // Reference: exact integer square root of the scaled significand, then RNE.
    function automatic void ref_sqrt(input logic [31:0] a, output logic [31:0] r,
                                     output logic [4:0] f, output bit spec);
        logic [7:0]  ex;
        logic [22:0] fr;
        longint      one, m, x, q, sig;
        int          e, eb;
        ex = a[30:23]; fr = a[22:0]; one = 1; spec = 1'b1; f = 5'd0; r = 32'd0;
        if (ex == 8'hFF && fr != 0) begin
            r = 32'h7FC00000; f = a[22] ? 5'h00 : 5'h10;
        end else if (ex == 8'h00 && fr == 0) begin
            r = {a[31], 31'd0};
        end else if (a[31]) begin
            r = 32'h7FC00000; f = 5'h10;
        end else if (ex == 8'hFF) begin
            r = 32'h7F800000;
        end else begin
            spec = 1'b0;
            m = longint'(fr) + ((ex != 0) ? (one << 23) : 0);
            e = (ex == 0) ? -126 : int'(ex) - 127;
            while (m < (one << 23)) begin m = m * 2; e = e - 1; end
            if (e % 2 != 0) begin m = m * 2; e = e - 1; end
            x   = m * (one << 25);
            q   = isqrt(x);
            sig = q / 2 + q % 2;
            eb  = e / 2 + 127;
            if (sig == (one << 24)) begin sig = one << 23; eb = eb + 1; end
            r = {1'b0, 8'(eb), 23'(sig)};
            f = {4'b0000, ((q % 2) != 0) || (q * q != x)};
        end
    endfunction

    task automatic do_op(input logic [31:0] a, output logic [31:0] r, output logic [4:0] f,
                         output int lat);
        int guard;
        lat = -1; r = 32'hxxxxxxxx; f = 5'bxxxxx; guard = 0;
        while (!w_sr && guard < 50) begin @(posedge clk); #1; guard++; end
        op_a = a; sv = 1'b1;
        @(posedge clk); #1;
        sv = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (w_rv) begin lat = c; r = w_res; f = w_ff; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        if (sr1 !== 1'b1 || sr5 !== 1'b1) begin bad++; $display("FAIL rst_start_ready: got %b%b want 11", sr1, sr5); end
        total++;
        if (rv1 !== 1'b0 || rv5 !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got %b%b want 00", rv1, rv5); end
        total++;
        if (bz1 !== 1'b0 || bz5 !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b%b want 00", bz1, bz5); end
        total++;
        if (res1 !== 32'd0 || res5 !== 32'd0) begin bad++; $display("FAIL rst_result: got %h %h want 0", res1, res5); end
        total++;
        if (ff1 !== 5'd0 || ff5 !== 5'd0) begin bad++; $display("FAIL rst_fflags: got %h %h want 0", ff1, ff5); end
        total++;
    endtask

    task automatic test_directed();
        logic [31:0] ops  [10] = '{32'h40800000, 32'h40000000, 32'hBF800000, 32'h7F800001, 32'h7FC00000,
                                   32'h80000000, 32'h7F800000, 32'h00000001, 32'h00800000, 32'h41100000};
        logic [31:0] exps [10] = '{32'h40000000, 32'h3FB504F3, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                                   32'h80000000, 32'h7F800000, 32'h1A3504F3, 32'h20000000, 32'h40400000};
        logic [4:0]  expf [10] = '{5'h00, 5'h01, 5'h10, 5'h10, 5'h00, 5'h00, 5'h00, 5'h01, 5'h00, 5'h00};
        int          expl [10] = '{27, 27, 2, 2, 2, 2, 2, 27, 27, 27};
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        sel = 1'b0; rr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_op(ops[i], r, f, lat);
            if (r !== exps[i]) begin bad++; $display("FAIL dir_result op=%h: got %h want %h", ops[i], r, exps[i]); end
            total++;
            if (f !== expf[i]) begin bad++; $display("FAIL dir_fflags op=%h: got %h want %h", ops[i], f, expf[i]); end
            total++;
            if (lat != expl[i]) begin bad++; $display("FAIL dir_latency op=%h: got %0d want %0d", ops[i], lat, expl[i]); end
            total++;
        end
        sel = 1'b1;
        do_op(32'h40000000, r, f, lat);
        if (r !== 32'h3FB504F3 || f !== 5'h01) begin bad++; $display("FAIL k5_sqrt2: got %h/%h want 3fb504f3/01", r, f); end
        total++;
        if (lat != 7) begin bad++; $display("FAIL k5_latency: got %0d want 7", lat); end
        total++;
        do_op(32'hBF800000, r, f, lat);
        if (r !== 32'h7FC00000 || f !== 5'h10 || lat != 2) begin
            bad++; $display("FAIL k5_special: got %h/%h lat %0d want 7fc00000/10 lat 2", r, f, lat);
        end
        total++;
        sel = 1'b0;
    endtask

    task automatic test_random(input logic s, input int cnt);
        logic [31:0] specials [6] = '{32'h7F800000, 32'hFF800000, 32'h7FA00000, 32'hFFC00001, 32'h00000000, 32'h80000000};
        logic [31:0] a, r, er;
        logic [4:0]  f, ef;
        bit          spec;
        int          lat, elat;
        sel = s; rr = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            a = $urandom;
            if (i % 4 == 1) a = {9'd0, 23'($urandom)};
            else if (i % 4 == 2) a[31] = 1'b0;
            else if (i % 7 == 3) a = specials[$urandom_range(0, 5)];
            ref_sqrt(a, er, ef, spec);
            elat = spec ? 2 : ((s ? 5 : 25) + 2);
            do_op(a, r, f, lat);
            if (r !== er || f !== ef) begin
                bad++; $display("FAIL rand_k%0d op=%h: got %h/%h want %h/%h", s ? 5 : 1, a, r, f, er, ef);
            end
            total++;
            if (lat != elat) begin bad++; $display("FAIL rand_lat op=%h: got %0d want %0d", a, lat, elat); end
            total++;
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        int guard;
        sel = 1'b0; rr = 1'b0;
        op_a = 32'h40000000; sv = 1'b1;
        @(posedge clk); #1;
        sv = 1'b0; guard = 0;
        while (!w_rv && guard < 60) begin @(posedge clk); #1; guard++; end
        if (!w_rv) begin bad++; $display("FAIL bp_timeout: got res_valid 0 want 1"); end
        total++;
        op_a = 32'h40800000; sv = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (w_rv !== 1'b1 || w_res !== 32'h3FB504F3 || w_ff !== 5'h01) begin
                bad++; $display("FAIL bp_hold c=%0d: got %b %h %h want 1 3fb504f3 01", c, w_rv, w_res, w_ff);
            end
            total++;
            if (w_sr !== 1'b0) begin bad++; $display("FAIL bp_start_ready c=%0d: got %b want 0", c, w_sr); end
            total++;
        end
        rr = 1'b1;
        @(posedge clk); #1;
        sv = 1'b0;
        if (w_rv !== 1'b0 || w_sr !== 1'b1 || w_bz !== 1'b0) begin
            bad++; $display("FAIL bp_release: got rv=%b sr=%b busy=%b want 0 1 0", w_rv, w_sr, w_bz);
        end
        total++;
        @(posedge clk); #1;
        if (w_bz !== 1'b0) begin bad++; $display("FAIL bp_no_accept: got busy %b want 0", w_bz); end
        total++;
    endtask

    task automatic test_flush();
        logic [31:0] r;
        logic [4:0]  f;
        int          lat, seen;
        sel = 1'b0; rr = 1'b1;
        op_a = 32'h40000000; sv = 1'b1;
        @(posedge clk); #1;
        sv = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if (w_sr !== 1'b1 || w_bz !== 1'b0 || w_rv !== 1'b0) begin
            bad++; $display("FAIL flush_idle: got sr=%b busy=%b rv=%b want 1 0 0", w_sr, w_bz, w_rv);
        end
        total++;
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (w_rv) seen++; end
        if (seen != 0) begin bad++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
        total++;
        do_op(32'h41100000, r, f, lat);
        if (r !== 32'h40400000 || f !== 5'h00 || lat != 27) begin
            bad++; $display("FAIL flush_next_op: got %h/%h lat %0d want 40400000/00 lat 27", r, f, lat);
        end
        total++;
    endtask

    task automatic test_reset_mid();
        int seen;
        sel = 1'b0; rr = 1'b1;
        op_a = 32'h40800000; sv = 1'b1;
        @(posedge clk); #1;
        sv = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        if (w_sr !== 1'b1 || w_rv !== 1'b0 || w_bz !== 1'b0) begin
            bad++; $display("FAIL arst_ctrl: got sr=%b rv=%b busy=%b want 1 0 0", w_sr, w_rv, w_bz);
        end
        total++;
        if (w_res !== 32'd0 || w_ff !== 5'd0) begin
            bad++; $display("FAIL arst_result: got %h/%h want 00000000/00", w_res, w_ff);
        end
        total++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        repeat (35) begin @(posedge clk); #1; if (w_rv || w_bz) seen++; end
        if (seen != 0) begin bad++; $display("FAIL arst_no_result: got %0d active cycles want 0", seen); end
        total++;
    endtask

    task automatic test_back_to_back(input logic s, input logic [31:0] a, input int want);
        int idx [3];
        int n, guard;
        sel = s; rr = 1'b1; n = 0;
        idx = '{-1, -1, -1};
        op_a = a; sv = 1'b1;
        for (int c = 0; c < 80 && n < 3; c++) begin
            if (w_sr) begin idx[n] = c; n++; end
            @(posedge clk); #1;
        end
        sv = 1'b0;
        guard = 0;
        while (w_bz && guard < 40) begin @(posedge clk); #1; guard++; end
        if (n < 3 || idx[1] - idx[0] != want || idx[2] - idx[1] != want) begin
            bad++; $display("FAIL b2b_interval k=%0d op=%h: got %0d,%0d want %0d", s ? 5 : 1, a,
                            idx[1] - idx[0], idx[2] - idx[1], want);
        end
        total++;
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; sv = 1'b0; rr = 1'b1; sel = 1'b0; op_a = 32'd0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_directed();
        test_random(1'b0, 150);
        test_random(1'b1, 150);
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back(1'b0, 32'h40800000, 29);
        test_back_to_back(1'b1, 32'h40800000, 9);
        test_back_to_back(1'b0, 32'h7F800000, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
